// File: rtl/btb_pkg.sv
// btb_pkg: shared opcodes, PC-select encodings, counter states and FSM states
// for the branch-prediction fetch controller.
package btb_pkg;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] PCSRC_INC4    = 2'b00;
    localparam logic [1:0] PCSRC_CTRL_NT = 2'b10;
    localparam logic [1:0] PCSRC_BTB     = 2'b11;

    typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_e;
    typedef enum logic {NORMAL = 1'b0, RECOVER = 1'b1} state_e;

    function automatic logic is_ctrl_op(input logic [6:0] op);
        return (op == OP_JAL) || (op == OP_JALR) || (op == OP_BRANCH);
    endfunction
endpackage

// File: rtl/btb_fetch_ctrl_if.sv
// btb_fetch_ctrl_if: IF/EX pipeline <-> predictor bus; the stats counters
// exist only when BTB_STATS_EN is defined.
interface btb_fetch_ctrl_if;
    logic [31:0] if_pc;
    logic        if_is_ctrl;
    logic [1:0]  pc_src;
    logic [31:0] btb_target;
    logic        pred_taken;
    logic        ex_valid;
    logic [6:0]  ex_opcode;
    logic [31:0] ex_pc;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        btb_clear;
    logic        mispredicted;
    logic [31:0] recover_pc;
    logic        flush_if_id;
    logic        flush_id_ex;
`ifdef BTB_STATS_EN
    logic [31:0] stat_lookups;
    logic [31:0] stat_mispredicts;
`endif

    modport master (
        output if_pc, if_is_ctrl, ex_valid, ex_opcode, ex_pc, ex_pred_taken,
               ex_pred_target, ex_taken, ex_target, btb_clear,
        input  pc_src, btb_target, pred_taken, mispredicted, recover_pc,
               flush_if_id, flush_id_ex
`ifdef BTB_STATS_EN
        , input stat_lookups, stat_mispredicts
`endif
    );

    modport slave (
        input  if_pc, if_is_ctrl, ex_valid, ex_opcode, ex_pc, ex_pred_taken,
               ex_pred_target, ex_taken, ex_target, btb_clear,
        output pc_src, btb_target, pred_taken, mispredicted, recover_pc,
               flush_if_id, flush_id_ex
`ifdef BTB_STATS_EN
        , output stat_lookups, stat_mispredicts
`endif
    );
endinterface

// File: rtl/btb_fetch_ctrl_sat_ctr2.sv
// sat_ctr2: next-state function of a 2-bit saturating up/down counter.
module sat_ctr2
    import btb_pkg::*;
(
    input  logic [1:0] i_ctr,
    input  logic       i_up,
    output logic [1:0] o_ctr
);
    always_comb begin
        o_ctr = i_up ? ((i_ctr == ST)  ? ST  : i_ctr + 2'd1)
                     : ((i_ctr == SNT) ? SNT : i_ctr - 2'd1);
    end
endmodule

// File: rtl/btb_fetch_ctrl.sv
// btb_fetch_ctrl: direct-mapped BTB with 2-bit counters, EX resolution and flush FSM.
// Define BTB_STATS_EN to add lookup/mispredict counters.
module btb_fetch_ctrl
    import btb_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int PC_W    = 12
) (
    input  logic CLK,
    input  logic RESET_N,
    btb_fetch_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - 2 - IDX_W;

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [PC_W-1:0]    r_target [ENTRIES];
    logic [1:0]         r_ctr    [ENTRIES];
    state_e             r_state;
    state_e             w_next_state;

    logic [IDX_W-1:0] w_if_idx, w_ex_idx;
    logic [TAG_W-1:0] w_if_tag, w_ex_tag;
    logic             w_if_hit, w_ex_hit, w_ex_ctrl, w_ex_jump, w_update, w_mispred;
    logic [1:0]       w_ctr_step;

    assign w_if_idx = bus.if_pc[2 +: IDX_W];
    assign w_if_tag = bus.if_pc[2 + IDX_W +: TAG_W];
    assign w_ex_idx = bus.ex_pc[2 +: IDX_W];
    assign w_ex_tag = bus.ex_pc[2 + IDX_W +: TAG_W];

    assign w_if_hit  = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign w_ex_hit  = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
    assign w_ex_ctrl = bus.ex_valid && is_ctrl_op(bus.ex_opcode);
    assign w_ex_jump = (bus.ex_opcode == OP_JAL) || (bus.ex_opcode == OP_JALR);
    assign w_update  = w_ex_ctrl && (r_state == NORMAL);
    assign w_mispred = w_update && ((bus.ex_taken != bus.ex_pred_taken) ||
                       (bus.ex_taken && (bus.ex_target != bus.ex_pred_target)));

    assign bus.pc_src       = {bus.if_is_ctrl, bus.if_is_ctrl && w_if_hit && r_ctr[w_if_idx][1]};
    assign bus.pred_taken   = bus.pc_src[0];
    assign bus.btb_target   = w_if_hit ? {{(32-PC_W){1'b0}}, r_target[w_if_idx]} : 32'd0;
    assign bus.mispredicted = w_mispred;
    assign bus.recover_pc   = bus.ex_pc;

    sat_ctr2 u_sat_ctr2 (
        .i_ctr (r_ctr[w_ex_idx]),
        .i_up  (bus.ex_taken),
        .o_ctr (w_ctr_step)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) r_state <= NORMAL;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = (r_state == RECOVER) ? NORMAL : (w_mispred ? RECOVER : NORMAL);
    end

    // RECOVER kills the wrong-path instruction that is entering EX
    always_comb begin
        bus.flush_if_id = w_mispred;
        bus.flush_id_ex = w_mispred || (r_state == RECOVER);
    end

    // Clear wins over a same-cycle update
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N || bus.btb_clear) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= WNT;
        end else if (w_update) begin
            if (w_ex_hit) begin
                if (bus.ex_taken) r_target[w_ex_idx] <= bus.ex_target[PC_W-1:0];
                r_ctr[w_ex_idx] <= w_ex_jump ? ST : w_ctr_step;
            end else if (bus.ex_taken) begin
                r_valid[w_ex_idx]  <= 1'b1;
                r_tag[w_ex_idx]    <= w_ex_tag;
                r_target[w_ex_idx] <= bus.ex_target[PC_W-1:0];
                r_ctr[w_ex_idx]    <= w_ex_jump ? ST : WT;
            end
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] r_stat_lookups, r_stat_mispredicts;
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_stat_lookups     <= '0;
            r_stat_mispredicts <= '0;
        end else begin
            r_stat_lookups     <= r_stat_lookups + {31'd0, bus.if_is_ctrl};
            r_stat_mispredicts <= r_stat_mispredicts + {31'd0, w_mispred};
        end
    end
    assign bus.stat_lookups     = r_stat_lookups;
    assign bus.stat_mispredicts = r_stat_mispredicts;
`endif
endmodule

// File: doc/btb_fetch_ctrl.md
Name: btb_fetch_ctrl

Overview:
- Branch-prediction controller that drives the fetch PC select: BTB lookup in IF, resolution and table update in EX, misprediction and flush generation.
- Produces the 2-bit PC source code, the BTB target, the misprediction flag and the recovery PC consumed by the PC mux.
- Sits between the IF/EX pipeline stages and the PC mux.
- Owns all BTB and 2-bit-counter state.

Parameters:
- ENTRIES, 16, number of direct-mapped BTB entries (power of two).
- PC_W, 12, significant PC bits; index = pc[2+IDX_W-1:2], tag = pc[PC_W-1:2+IDX_W], IDX_W = log2(ENTRIES).

Ports:
- CLK  in  1  clock
- RESET_N  in  1  async active-low reset
- if_pc  in  32  PC being fetched
- if_is_ctrl  in  1  predecode: IF instruction is JAL/JALR/BRANCH
- pc_src  out  2  bit1 = control instr in IF, bit0 = BTB hit and predicted taken
- btb_target  out  32  predicted target (zero-extended stored target)
- pred_taken  out  1  equals pc_src[0]; carried down the pipe
- ex_valid  in  1  EX holds a live (non-flushed) instruction
- ex_opcode  in  7  EX opcode
- ex_pc  in  32  EX instruction PC
- ex_pred_taken  in  1  prediction carried from IF
- ex_pred_target  in  32  target carried from IF
- ex_taken  in  1  actual outcome (branch ALU result; 1 for JAL/JALR)
- ex_target  in  32  actual target
- btb_clear  in  1  synchronous invalidate-all
- mispredicted  out  1  EX resolution differs from prediction
- recover_pc  out  32  = ex_pc (mux adds 4 for not-taken recovery)
- flush_if_id  out  1  squash IF/ID register
- flush_id_ex  out  1  squash ID/EX register

Behaviour:
- Entry state: valid, tag[PC_W-2-IDX_W], target[PC_W], ctr[2].
- Reset: all valid=0, ctr=2'b01, state NORMAL, all outputs 0.
- Lookup is combinational and same-cycle.
  - hit = valid & tag match.
  - pc_src[1] = if_is_ctrl.
  - pc_src[0] = if_is_ctrl & hit & ctr[1].
  - btb_target = zero-extended target; 0 when no hit.
- ex_ctrl = ex_valid & opcode in {1101111 JAL, 1100111 JALR, 1100011 BRANCH}.
- mispredicted = ex_ctrl & state==NORMAL & (ex_taken != ex_pred_taken | (ex_taken & ex_target != ex_pred_target)).
- recover_pc = ex_pc.
- FSM:
  - NORMAL: on mispredicted, flush_if_id = flush_id_ex = 1 (combinational), next state RECOVER.
  - RECOVER (exactly one cycle): flush_id_ex = 1 to kill the wrong-path instruction entering EX; mispredicted forced 0; table updates suppressed; next state NORMAL.
- Update at posedge when ex_ctrl & state==NORMAL:
  - Tag miss and ex_taken: allocate (valid=1, tag, target=ex_target[PC_W-1:0]).
    - ctr = 2'b11 for JAL/JALR, 2'b10 for BRANCH.
  - Tag miss and not taken: no allocation.
  - Tag hit: target <= ex_target if taken.
    - Taken: ctr saturating increment (max 2'b11).
    - Not taken: ctr saturating decrement (min 2'b00).
    - JAL/JALR: ctr forced to 2'b11.
- Simultaneous lookup and update on the same index: lookup sees pre-edge contents (no bypass).
- btb_clear: at next edge all valid=0, ctr=2'b01; it has priority over an update in the same cycle; the FSM is unaffected.
- Reset mid-RECOVER returns to NORMAL with flushes deasserted immediately (async).

Optional Feature:
- Macro: BTB_STATS_EN.
- Defined: adds outputs stat_lookups[31:0] (increments each cycle if_is_ctrl=1) and stat_mispredicts[31:0] (increments each cycle mispredicted=1).
  - Both counters wrap at 2^32, reset to 0, and are not cleared by btb_clear.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package btb_pkg:
  - opcode constants OP_JAL, OP_JALR, OP_BRANCH.
  - pc_src encodings PCSRC_INC4=2'b00, PCSRC_CTRL_NT=2'b10, PCSRC_BTB=2'b11.
  - counter encodings SNT/WNT/WT/ST.
  - FSM state enum NORMAL/RECOVER.
- Sub-module sat_ctr2: 2-bit saturating up/down counter next-state function, instantiated in the update path.

Test Plan:
- Reset, then lookup if_pc=0x040, if_is_ctrl=1 -> pc_src=2'b10, btb_target=0, mispredicted=0.
- EX BRANCH at ex_pc=0x040, ex_taken=1, ex_target=0x100, ex_pred_taken=0 -> mispredicted=1 and flush_if_id=flush_id_ex=1 that cycle, flush_id_ex=1 the next cycle; then lookup 0x040 -> pc_src=2'b11, btb_target=0x100.
- Same branch resolved not-taken twice, with ex_pred_taken matching the IF prediction -> ctr 10->01->00; lookup 0x040 -> pc_src=2'b10.
- Mispredict followed by a second mispredicting EX in the RECOVER cycle -> second mispredicted=0 and no table write.
- Aliasing: entry allocated for 0x040; EX JAL at 0x440 (same index, tag differs) taken to 0x200 -> entry replaced; lookup 0x040 misses, lookup 0x440 -> target 0x200, pc_src=2'b11.
- btb_clear asserted in the same cycle as an allocating update -> every lookup misses afterwards; with BTB_STATS_EN, stat_mispredicts keeps its value.
